// File: rtl/image_loader_pkg.sv
// Shared definitions for the image loader and the processor datapath that
// consumes the loaded image: bus widths and state encodings.
package image_loader_pkg;

   localparam int ADDR_W = 19;  // pixel address into the input image memory
   localparam int DIM_W  = 12;  // image height / width
   localparam int DATA_W = 8;   // pixel data and UART byte

   // Loader control states; HDR0..LOAD count as busy.
   typedef enum logic [2:0] {
      HDR0  = 3'd0,
      HDR1  = 3'd1,
      HDR2  = 3'd2,
      HDR3  = 3'd3,
      CHECK = 3'd4,
      LOAD  = 3'd5,
      DONE  = 3'd6,
      ERR   = 3'd7
   } state_t;

   // Serial receiver phases.
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/image_loader_if.sv
// Write port into the input image memory (MI). The loader drives it as
// master; the memory (or a bench monitor) observes it as slave.
interface image_loader_if;
   import image_loader_pkg::*;

   logic              MI_wr;
   logic [ADDR_W-1:0] MI_wr_add;
   logic [DATA_W-1:0] MI_wr_data;

   modport master (output MI_wr, output MI_wr_add, output MI_wr_data);
   modport slave  (input  MI_wr, input  MI_wr_add, input  MI_wr_data);
endinterface

// File: rtl/image_loader_uart_rx_8n1.sv
// 8N1 UART receiver: two-flop synchroniser, falling-edge start detection,
// mid-bit sampling, one-cycle byte_valid or frame_err_pulse per frame.
module uart_rx_8n1
   import image_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx,
   output logic [DATA_W-1:0] byte_out,
   output logic              byte_valid,
   output logic              frame_err_pulse
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic              rx_meta, rx_sync, rx_prev;
   rx_state_t         rx_state, rx_state_nxt;
   logic [CNT_W-1:0]  clk_cnt, clk_cnt_nxt;
   logic [2:0]        bit_idx, bit_idx_nxt;
   logic [DATA_W-1:0] shift, shift_nxt;
   logic [DATA_W-1:0] byte_nxt;
   logic              valid_nxt, ferr_nxt;

   // Synchronise the line; flops reset high (idle) so reset release never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         // NOTE: sequential state always uses <=, so every flop samples pre-edge values regardless of statement order.
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Receiver state and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state        <= RX_IDLE;
         clk_cnt         <= '0;
         bit_idx         <= '0;
         shift           <= '0;
         byte_out        <= '0;
         byte_valid      <= 1'b0;
         frame_err_pulse <= 1'b0;
      end else begin
         rx_state        <= rx_state_nxt;
         clk_cnt         <= clk_cnt_nxt;
         bit_idx         <= bit_idx_nxt;
         shift           <= shift_nxt;
         byte_out        <= byte_nxt;
         byte_valid      <= valid_nxt;
         frame_err_pulse <= ferr_nxt;
      end
   end

   // Bit timing: confirm start at half a bit, then sample each bit one bit-time apart.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      rx_state_nxt = rx_state;
      clk_cnt_nxt  = clk_cnt + 1'b1;
      bit_idx_nxt  = bit_idx;
      shift_nxt    = shift;
      byte_nxt     = byte_out;
      valid_nxt    = 1'b0;
      ferr_nxt     = 1'b0;
      unique case (rx_state)
         RX_IDLE: begin
            clk_cnt_nxt = '0;
            if (rx_prev && !rx_sync) rx_state_nxt = RX_START;
         end
         RX_START: begin
            if (clk_cnt == HALF_LAST) begin
               clk_cnt_nxt  = '0;
               bit_idx_nxt  = '0;
               rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;  // glitch: back to idle
            end
         end
         RX_DATA: begin
            if (clk_cnt == BIT_LAST) begin
               clk_cnt_nxt = '0;
               shift_nxt   = {rx_sync, shift[DATA_W-1:1]};  // LSB first
               bit_idx_nxt = bit_idx + 1'b1;
               if (bit_idx == 3'd7) rx_state_nxt = RX_STOP;
            end
         end
         RX_STOP: begin
            if (clk_cnt == BIT_LAST) begin
               clk_cnt_nxt  = '0;
               rx_state_nxt = RX_IDLE;
               if (rx_sync) begin
                  byte_nxt  = shift;
                  valid_nxt = 1'b1;
               end else begin
                  ferr_nxt  = 1'b1;
               end
            end
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/image_loader.sv
// Image loader: receives a 4-byte header (H, W, 12 bits each) over UART,
// validates H*W, then writes H*W pixel bytes into the input image memory.
module image_loader
   import image_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int MAX_PIXELS   = 262144
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             uart_rx,
   input  logic             restart,
   image_loader_if.master   mem,
   output logic [DIM_W-1:0] img_h,
   output logic [DIM_W-1:0] img_w,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             frame_err
);

   localparam int AREA_W = 2 * DIM_W;
   localparam logic [AREA_W-1:0] MAX_AREA = AREA_W'(MAX_PIXELS);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] rx_byte;
   logic              rx_valid, rx_ferr;
   logic [ADDR_W-1:0] pix_cnt, last_addr;
   logic [AREA_W-1:0] area;
   logic              restart_ok;

   uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk             (clk),
      .rst_n           (rst_n),
      .rx              (uart_rx),
      .byte_out        (rx_byte),
      .byte_valid      (rx_valid),
      .frame_err_pulse (rx_ferr)
   );

   assign area       = AREA_W'(img_h) * AREA_W'(img_w);
   assign restart_ok = restart && (state == DONE || state == ERR);
   assign busy       = (state != DONE) && (state != ERR);
   assign done       = (state == DONE);
   assign err        = (state == ERR);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= HDR0;
      else        state <= state_nxt;
   end

   // Next state: header bytes, size check, load until the last address is written.
   always_comb begin
      state_nxt = state;
      unique case (state)
         HDR0:    if (rx_valid) state_nxt = HDR1;
         HDR1:    if (rx_valid) state_nxt = HDR2;
         HDR2:    if (rx_valid) state_nxt = HDR3;
         HDR3:    if (rx_valid) state_nxt = CHECK;
         CHECK:   state_nxt = (area == '0 || area > MAX_AREA) ? ERR : LOAD;
         LOAD:    if (mem.MI_wr && mem.MI_wr_add == last_addr) state_nxt = DONE;
         DONE,
         ERR:     if (restart) state_nxt = HDR0;
         default: state_nxt = HDR0;
      endcase
   end

   // Datapath: header capture, pixel writes, sticky frame error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem.MI_wr      <= 1'b0;
         mem.MI_wr_add  <= '0;
         mem.MI_wr_data <= '0;
         img_h          <= '0;
         img_w          <= '0;
         pix_cnt        <= '0;
         last_addr      <= '0;
         frame_err      <= 1'b0;
      end else begin
         mem.MI_wr <= 1'b0;
         if (restart_ok)   frame_err <= 1'b0;
         else if (rx_ferr) frame_err <= 1'b1;
         if (state == CHECK) begin
            pix_cnt   <= '0;
            last_addr <= ADDR_W'(area - 1'b1);  // area bounded by MAX_PIXELS, so no wrap
         end
         if (rx_valid) begin
            unique case (state)
               HDR0: img_h      <= {rx_byte[3:0], 8'h00};
               HDR1: img_h[7:0] <= rx_byte;
               HDR2: img_w      <= {rx_byte[3:0], 8'h00};
               HDR3: img_w[7:0] <= rx_byte;
               LOAD: begin
                  mem.MI_wr      <= 1'b1;
                  mem.MI_wr_add  <= pix_cnt;
                  mem.MI_wr_data <= rx_byte;
                  pix_cnt        <= pix_cnt + 1'b1;
               end
               default: ;  // CHECK, DONE, ERR: byte ignored
            endcase
         end
      end
   end

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: normal frame, bad headers, size boundary,
// framing error, mid-load reset, and bytes ignored while done.
module tb_image_loader;
   import image_loader_pkg::*;

   localparam int CPB = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             uart_rx = 1'b1;
   logic             restart = 1'b0;
   logic [DIM_W-1:0] img_h, img_w;
   logic             busy, done, err, frame_err;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];

   image_loader_if mi ();

   image_loader #(.CLKS_PER_BIT(CPB), .MAX_PIXELS(262144)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .uart_rx   (uart_rx),
      .restart   (restart),
      .mem       (mi),
      .img_h     (img_h),
      .img_w     (img_w),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   // Log every memory write, sampled away from the rising edge.
   always @(negedge clk) begin
      if (mi.MI_wr) begin
         wr_addr.push_back(32'(mi.MI_wr_add));
         wr_data.push_back(32'(mi.MI_wr_data));
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
   endtask

   // One 8N1 frame plus one idle bit; called and returns on a falling edge.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop_bit;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200 && !done; i++) @(negedge clk);
   endtask

   task automatic check_frame6(input string tag, input logic [7:0] base);
      check({tag, "_count"}, 32'(wr_addr.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         check({tag, "_addr"}, wr_addr[i], 32'(i));
         check({tag, "_data"}, wr_data[i], 32'(base) + 32'(i));
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 1);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_ferr", 32'(frame_err), 0);
      check("rst_wr", 32'(mi.MI_wr), 0);
      check("rst_h", 32'(img_h), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 3x2 frame
      clear_log();
      send_byte(8'h00); send_byte(8'h03); send_byte(8'h00); send_byte(8'h02);
      check("A_busy_load", 32'(busy), 1);
      for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
      wait_done();
      check_frame6("A", 8'h10);
      check("A_img_h", 32'(img_h), 3);
      check("A_img_w", 32'(img_w), 2);
      check("A_done", 32'(done), 1);
      check("A_busy", 32'(busy), 0);

      // Bytes while done are ignored
      clear_log();
      send_byte(8'h77); send_byte(8'h01);
      check("E_no_wr", 32'(wr_addr.size()), 0);
      check("E_img_h", 32'(img_h), 3);
      check("E_img_w", 32'(img_w), 2);
      check("E_done", 32'(done), 1);
      pulse_restart();
      check("E_rs_busy", 32'(busy), 1);
      check("E_rs_done", 32'(done), 0);

      // Zero height -> ERR
      clear_log();
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
      repeat (4) @(negedge clk);
      check("B_err", 32'(err), 1);
      check("B_busy", 32'(busy), 0);
      send_byte(8'h42);
      check("B_no_wr", 32'(wr_addr.size()), 0);
      pulse_restart();
      check("B_rs_busy", 32'(busy), 1);
      check("B_rs_err", 32'(err), 0);

      // 512x513 too large
      send_byte(8'h02); send_byte(8'h00); send_byte(8'h02); send_byte(8'h01);
      repeat (4) @(negedge clk);
      check("C_513_err", 32'(err), 1);
      pulse_restart();

      // 512x512 accepted; jump counter near the end and finish the image
      clear_log();
      send_byte(8'h02); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
      repeat (4) @(negedge clk);
      check("C_512_err", 32'(err), 0);
      check("C_512_busy", 32'(busy), 1);
      send_byte(8'hA0); send_byte(8'hA1);
      check("C_first_addr", wr_addr[0], 0);
      check("C_second_addr", wr_addr[1], 1);
      force dut.pix_cnt = 19'd262142;
      @(negedge clk);
      release dut.pix_cnt;
      @(negedge clk);
      clear_log();
      send_byte(8'hAA);
      check("C_mid_done", 32'(done), 0);
      send_byte(8'hBB);
      wait_done();
      check("C_count", 32'(wr_addr.size()), 2);
      check("C_pen_addr", wr_addr[0], 262142);
      check("C_last_addr", wr_addr[1], 262143);
      check("C_last_data", wr_data[1], 32'hBB);
      check("C_done", 32'(done), 1);
      pulse_restart();

      // Framing error during LOAD
      clear_log();
      send_byte(8'h00); send_byte(8'h03); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h10); send_byte(8'h11);
      send_byte(8'h55, 1'b0);
      check("D_ferr", 32'(frame_err), 1);
      check("D_no_wr", 32'(wr_addr.size()), 2);
      for (int i = 2; i < 6; i++) send_byte(8'h10 + 8'(i));
      wait_done();
      check_frame6("D", 8'h10);
      check("D_done", 32'(done), 1);
      check("D_ferr_sticky", 32'(frame_err), 1);
      pulse_restart();
      check("D_ferr_clr", 32'(frame_err), 0);

      // Reset after 3 of 6 pixels, mid-byte
      send_byte(8'h00); send_byte(8'h03); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h20); send_byte(8'h21); send_byte(8'h22);
      uart_rx = 1'b0;
      repeat (6) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("F_busy", 32'(busy), 1);
      check("F_done", 32'(done), 0);
      check("F_wr", 32'(mi.MI_wr), 0);
      check("F_add", 32'(mi.MI_wr_add), 0);
      check("F_data", 32'(mi.MI_wr_data), 0);
      check("F_img_h", 32'(img_h), 0);
      check("F_img_w", 32'(img_w), 0);
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      clear_log();
      send_byte(8'h00); send_byte(8'h03); send_byte(8'h00); send_byte(8'h02);
      for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i));
      wait_done();
      check_frame6("F", 8'h30);
      check("F_done_end", 32'(done), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit (50 MHz / 115200).
REQ-002 SHALL have parameter MAX_PIXELS, default 262144, meaning the largest accepted H*W (512x512).
REQ-003 SHALL have port clk  input  1  meaning the single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port uart_rx  input  1  meaning serial 8N1 line, idle high, asynchronous to clk.
REQ-006 SHALL have port restart  input  1  meaning a one-cycle pulse that returns the block from DONE or ERR to header reception.
REQ-007 SHALL have port MI_wr  output  1  meaning the write strobe to the input image memory.
REQ-008 SHALL have port MI_wr_add  output  19  meaning the write address.
REQ-009 SHALL have port MI_wr_data  output  8  meaning the write data.
REQ-010 SHALL have port img_h  output  12  meaning the received image height, for loading into RH.
REQ-011 SHALL have port img_w  output  12  meaning the received image width, for loading into RW.
REQ-012 SHALL have port busy  output  1  meaning high in the HDR0..LOAD states.
REQ-013 SHALL have port done  output  1  meaning a level that is high in DONE and serves as the processor start.
REQ-014 SHALL have port err  output  1  meaning a level that is high in ERR.
REQ-015 SHALL have port frame_err  output  1  meaning a sticky flag set on a bad stop bit and cleared by restart.

Function
REQ-016 SHALL synchronise uart_rx through two flip-flops before any use.
REQ-017 SHALL detect a start bit on a falling edge, re-check it low at CLKS_PER_BIT/2, then sample 8 data bits (LSB first) and the stop bit, each CLKS_PER_BIT apart.
REQ-018 SHALL emit a one-cycle byte-valid after the stop-bit sample when the stop bit is 1; a stop bit of 0 SHALL drop the byte and set frame_err.
REQ-019 SHALL use the states HDR0, HDR1, HDR2, HDR3, CHECK, LOAD, DONE and ERR.
REQ-020 SHALL, on a valid byte in HDR0..HDR3, capture in order H[11:8] (low nibble), H[7:0], W[11:8] and W[7:0], then go to CHECK.
REQ-021 SHALL, in CHECK, compute H*W in one cycle: H=0, W=0 or H*W>MAX_PIXELS goes to ERR; otherwise the block goes to LOAD with the pixel counter at 0.
REQ-022 SHALL, in LOAD, assert MI_wr for exactly the one cycle after each valid byte, with MI_wr_data set to the byte and MI_wr_add set to the counter; the counter SHALL then increment.
REQ-023 SHALL go from LOAD to DONE on the cycle after the write at address H*W-1.
REQ-024 SHALL ignore all received bytes in DONE and ERR; restart SHALL go to HDR0 and clear frame_err.
REQ-025 SHALL ignore restart while busy.
REQ-026 SHALL hold MI_wr at 0 outside LOAD; MI_wr_add and MI_wr_data SHALL hold their last values.
REQ-027 SHALL hold img_h and img_w stable from CHECK until the next HDR0 capture.
REQ-028 SHALL keep the counter 19 bits wide; because of REQ-021 it SHALL never wrap.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-byte or mid-LOAD, immediately force: state HDR0, receiver idle, counter 0, MI_wr 0, MI_wr_add 0, MI_wr_data 0, img_h 0, img_w 0, done 0, err 0, frame_err 0, busy 1.
REQ-030 SHALL keep the synchroniser flip-flops reset high so that no false start bit occurs on reset release.

Structure
REQ-031 SHALL put the state encoding, ADDR_W=19, DIM_W=12 and DATA_W=8 in the shared package used by the processor datapath.
REQ-032 SHALL implement the serial receiver as one sub-module, uart_rx_8n1, with ports clk, rst_n, rx, byte_out[7:0], byte_valid and frame_err_pulse.
REQ-033 SHALL fit within 120-400 lines of RTL including the sub-module.

Verification (bench uses CLKS_PER_BIT=4, MAX_PIXELS=262144)
REQ-034 SHALL cover: header 00 03 00 02, then bytes 10 11 12 13 14 15 -> six MI_wr pulses at addresses 0..5 with data 10..15, img_h=3, img_w=2, then done=1.
REQ-035 SHALL cover: header 00 00 00 05 -> err=1, no MI_wr, and a subsequent restart -> busy=1, err=0.
REQ-036 SHALL cover: header 02 00 02 01 (512x513) -> err=1; header 02 00 02 00 -> LOAD accepted and the last write is at address 262143.
REQ-037 SHALL cover: a byte with stop bit 0 during LOAD -> frame_err=1, no write, and the counter unchanged.
REQ-038 SHALL cover: rst_n low after 3 of 6 pixels -> all outputs reach reset values within the same cycle; a full new frame then loads from address 0.
REQ-039 SHALL cover: bytes sent while done=1 -> no MI_wr and no change to img_h or img_w.
